// File: rtl/uv_fault_pkg.sv
// Shared encodings and constants for the multi-channel ultrasonic fault scanner.
package uv_fault_pkg;

   typedef enum logic [1:0] {
      ChUnk   = 2'b00,
      ChClear = 2'b01,
      ChFault = 2'b10,
      ChError = 2'b11
   } ch_state_e;

   typedef enum logic [2:0] {ScTrig, ScWait, ScMeas, ScDone, ScGap} scan_state_e;

   localparam int unsigned ChIdxW      = 6;
   localparam int unsigned MsgChLsb    = 0;
   localparam int unsigned MsgStateLsb = 6;
   localparam int unsigned MmMul       = 11;
   localparam int unsigned MmShift     = 6;

   function automatic logic [7:0] make_msg(input ch_state_e st, input logic [ChIdxW-1:0] ch);
      logic [7:0] m;
      m = '0;
      m[MsgStateLsb +: 2] = st;
      m[MsgChLsb +: ChIdxW] = ch;
      return m;
   endfunction

endpackage

// File: rtl/uv_echo_meter.sv
// Echo synchroniser, edge qualification and microsecond pulse-width counter
// for the currently selected sensor channel.
module uv_echo_meter #(
   parameter int unsigned N_CH       = 3,
   parameter int unsigned US_CYC     = 50,
   parameter int unsigned PERIOD_CYC = 50_000,
   parameter int unsigned US_W       = 19,
   parameter int unsigned CH_W       = 2,
   parameter int unsigned SLOT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   echo_pin,
   input  logic [CH_W-1:0]   ch,
   input  logic [SLOT_W-1:0] slot,
   input  logic              arm,
   input  logic              measure,
   output logic              rise,
   output logic              fall,
   output logic              timeout,
   output logic [US_W-1:0]   echo_us
);

   localparam int unsigned PRE_W = (US_CYC > 1) ? $clog2(US_CYC) : 1;

   logic [N_CH-1:0]  sync1_q, sync2_q;
   logic             seen_low_q, seen_low_d;
   logic [PRE_W-1:0] pre_q, pre_d, pre_base;
   logic [US_W-1:0]  us_q, us_d, us_base;
   logic             sel, count;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         seen_low_q <= 1'b0;
         pre_q      <= '0;
         us_q       <= '0;
      end else begin
         sync1_q    <= echo_pin;
         sync2_q    <= sync1_q;
         seen_low_q <= seen_low_d;
         pre_q      <= pre_d;
         us_q       <= us_d;
      end
   end

   always_comb begin
      sel        = sync2_q[ch];
      // A rise only counts once the echo has been seen low inside the wait window.
      rise       = arm && sel && seen_low_q;
      fall       = measure && !sel;
      timeout    = (arm || measure) && (slot == SLOT_W'(PERIOD_CYC - 2));
      seen_low_d = arm && (seen_low_q || !sel);
      count      = rise || (measure && sel);
      pre_base   = arm ? '0 : pre_q;
      us_base    = arm ? '0 : us_q;
      pre_d      = pre_base;
      us_d       = us_base;
      if (count) begin
         if (pre_base == PRE_W'(US_CYC - 1)) begin
            pre_d = '0;
            if (us_base != '1) us_d = us_base + US_W'(1);
         end else begin
            pre_d = pre_base + PRE_W'(1);
         end
      end
      echo_us = us_q;
   end

endmodule

// File: rtl/uv_fault_scanner.sv
// Round-robin ultrasonic scanner: per-slot trigger, echo timing, mm conversion,
// classification and per-channel confirmation driving RGB LEDs and status messages.
module uv_fault_scanner
   import uv_fault_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned N_CH       = 3,
   parameter int unsigned TRIG_CYC   = 500,
   parameter int unsigned PERIOD_CYC = 50_000,
   parameter int unsigned DIST_W     = 16,
   parameter int unsigned FAULT_MM   = 40,
   parameter int unsigned CONFIRM    = 3
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic [N_CH-1:0]   UV_echo,
   output logic [N_CH-1:0]   UV_trig,
   output logic [N_CH-1:0]   led_R,
   output logic [N_CH-1:0]   led_G,
   output logic [N_CH-1:0]   led_B,
   output logic [7:0]        msg,
   output logic              msg_valid,
   output logic [5:0]        meas_ch,
   output logic [DIST_W-1:0] meas_mm,
   output logic              meas_valid
);

   localparam int unsigned US_CYC = CLK_HZ / 1_000_000;
   localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned SLOT_W = $clog2(PERIOD_CYC);
   localparam int unsigned US_W   = DIST_W + 3;
   localparam int unsigned PROD_W = US_W + 4;
   localparam int unsigned CNT_W  = $clog2(CONFIRM + 1);

   scan_state_e       scan_q, scan_d;
   logic [CH_W-1:0]   ch_q, ch_d, ch_next;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              err_q, err_d;
   ch_state_e         st_q [N_CH];
   ch_state_e         st_d [N_CH];
   ch_state_e         pend_q [N_CH];
   ch_state_e         pend_d [N_CH];
   logic [CNT_W-1:0]  cnt_q [N_CH];
   logic [CNT_W-1:0]  cnt_d [N_CH];
   logic [7:0]        msg_q, msg_d;
   logic              msg_valid_q, msg_valid_d;
   logic [5:0]        meas_ch_q, meas_ch_d;
   logic [DIST_W-1:0] meas_mm_q, meas_mm_d;
   logic              meas_valid_q, meas_valid_d;

   logic              rise, fall, timeout, slot_last;
   logic [US_W-1:0]   echo_us;
   logic [PROD_W-1:0] prod, mm_wide;
   logic [DIST_W-1:0] mm;
   ch_state_e         cls, pend_new;
   logic [CNT_W-1:0]  cnt_new;

   uv_echo_meter #(
      .N_CH       (N_CH),
      .US_CYC     (US_CYC),
      .PERIOD_CYC (PERIOD_CYC),
      .US_W       (US_W),
      .CH_W       (CH_W),
      .SLOT_W     (SLOT_W)
   ) u_meter (
      .clk      (clk_50M),
      .reset    (reset),
      .echo_pin (UV_echo),
      .ch       (ch_q),
      .slot     (slot_q),
      .arm      (scan_q == ScWait),
      .measure  (scan_q == ScMeas),
      .rise     (rise),
      .fall     (fall),
      .timeout  (timeout),
      .echo_us  (echo_us)
   );

   always_ff @(posedge clk_50M) begin
      if (reset) begin
         // Parked on the last cycle of the last slot so the first free-running
         // cycle is TRIG, channel 0, slot cycle 0, with the trigger held low meanwhile.
         scan_q       <= ScGap;
         ch_q         <= CH_W'(N_CH - 1);
         slot_q       <= SLOT_W'(PERIOD_CYC - 1);
         err_q        <= 1'b0;
         st_q         <= '{default: ChUnk};
         pend_q       <= '{default: ChUnk};
         cnt_q        <= '{default: '0};
         msg_q        <= '0;
         msg_valid_q  <= 1'b0;
         meas_ch_q    <= '0;
         meas_mm_q    <= '0;
         meas_valid_q <= 1'b0;
      end else begin
         scan_q       <= scan_d;
         ch_q         <= ch_d;
         slot_q       <= slot_d;
         err_q        <= err_d;
         st_q         <= st_d;
         pend_q       <= pend_d;
         cnt_q        <= cnt_d;
         msg_q        <= msg_d;
         msg_valid_q  <= msg_valid_d;
         meas_ch_q    <= meas_ch_d;
         meas_mm_q    <= meas_mm_d;
         meas_valid_q <= meas_valid_d;
      end
   end

   always_comb begin
      prod    = PROD_W'(echo_us) * PROD_W'(MmMul);
      mm_wide = prod >> MmShift;
      mm      = (mm_wide > PROD_W'({DIST_W{1'b1}})) ? '1 : mm_wide[DIST_W-1:0];
      if (err_q)                        cls = ChError;
      else if (mm <= DIST_W'(FAULT_MM)) cls = ChFault;
      else                              cls = ChClear;
   end

   always_comb begin
      scan_d       = scan_q;
      ch_d         = ch_q;
      err_d        = err_q;
      st_d         = st_q;
      pend_d       = pend_q;
      cnt_d        = cnt_q;
      msg_d        = msg_q;
      msg_valid_d  = 1'b0;
      meas_ch_d    = meas_ch_q;
      meas_mm_d    = meas_mm_q;
      meas_valid_d = 1'b0;
      pend_new     = pend_q[ch_q];
      cnt_new      = cnt_q[ch_q];
      slot_last    = (slot_q == SLOT_W'(PERIOD_CYC - 1));
      slot_d       = slot_last ? '0 : slot_q + SLOT_W'(1);
      ch_next      = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);

      case (scan_q)
         ScTrig: if (slot_q == SLOT_W'(TRIG_CYC - 1)) scan_d = ScWait;
         ScWait: begin
            if (timeout) begin
               scan_d = ScDone;
               err_d  = 1'b1;
            end else if (rise) begin
               scan_d = ScMeas;
            end
         end
         ScMeas: begin
            if (timeout) begin
               scan_d = ScDone;
               err_d  = 1'b1;
            end else if (fall) begin
               scan_d = ScDone;
               err_d  = 1'b0;
            end
         end
         ScDone: begin
            meas_valid_d = 1'b1;
            meas_ch_d    = 6'(ch_q);
            meas_mm_d    = err_q ? '0 : mm;
            if (cls == pend_q[ch_q]) begin
               cnt_new = (cnt_q[ch_q] == CNT_W'(CONFIRM)) ? cnt_q[ch_q]
                                                          : cnt_q[ch_q] + CNT_W'(1);
            end else begin
               pend_new = cls;
               cnt_new  = CNT_W'(1);
            end
            pend_d[ch_q] = pend_new;
            cnt_d[ch_q]  = cnt_new;
            if (cnt_new == CNT_W'(CONFIRM) && pend_new != st_q[ch_q]) begin
               st_d[ch_q]  = pend_new;
               msg_d       = make_msg(pend_new, 6'(ch_q));
               msg_valid_d = 1'b1;
            end
            if (slot_last) begin
               scan_d = ScTrig;
               ch_d   = ch_next;
            end else begin
               scan_d = ScGap;
            end
         end
         ScGap: begin
            if (slot_last) begin
               scan_d = ScTrig;
               ch_d   = ch_next;
            end
         end
         default: scan_d = ScTrig;
      endcase
   end

   always_comb begin
      UV_trig = '0;
      if (scan_q == ScTrig) UV_trig[ch_q] = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         led_R[i] = (st_q[i] == ChFault);
         led_G[i] = (st_q[i] == ChClear);
         led_B[i] = (st_q[i] == ChError);
      end
   end

   assign msg        = msg_q;
   assign msg_valid  = msg_valid_q;
   assign meas_ch    = meas_ch_q;
   assign meas_mm    = meas_mm_q;
   assign meas_valid = meas_valid_q;

endmodule

// File: doc/uv_fault_scanner.md
# uv_fault_scanner

Multi-channel successor to the single-sensor ultrasonic fault detector. Fires N_CH ultrasonic sensors one at a time in round-robin slots, times each echo in microseconds, converts it to millimetres, classifies it as clear/fault/sensor-error, and confirms each class over consecutive scans before updating that channel's RGB LED and emitting an 8-bit status message. It sits between the sensor pins and the LED/UART message path of the bot's fault-detection subsystem.

## Interface
- CLK_HZ, 50_000_000, clock frequency; US_CYC = CLK_HZ/1_000_000 cycles per µs
- N_CH, 3, number of sensor channels, 1..64
- TRIG_CYC, 500, trigger pulse width in cycles (10 µs)
- PERIOD_CYC, 50_000, slot length in cycles per channel (1 ms)
- DIST_W, 16, distance width in mm
- FAULT_MM, 40, distance at or below this value (mm) is a fault
- CONFIRM, 3, consecutive identical classes needed to change reported state, ≥1
- clk_50M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- UV_echo  in  N_CH  echo inputs, asynchronous
- UV_trig  out  N_CH  trigger outputs
- led_R / led_G / led_B  out  N_CH each  per-channel RGB LED drives, active-high
- msg  out  8  last status message {state[1:0], ch[5:0]}
- msg_valid  out  1  one-cycle pulse when msg updates
- meas_ch  out  6  channel of last measurement
- meas_mm  out  DIST_W  last measured distance (0 on error)
- meas_valid  out  1  one-cycle pulse per completed slot

## Operation
- State encoding per channel: UNK=00 (LED off), CLEAR=01 (green), FAULT=10 (red), ERROR=11 (blue). Exactly one LED colour on per non-UNK channel.
- Scanner FSM: TRIG → WAIT_ECHO → MEASURE → DONE → GAP → (next channel) TRIG. Channel index wraps N_CH-1 → 0.
- TRIG: UV_trig[ch] high for slot cycles 0..TRIG_CYC-1; all other triggers always low.
- WAIT_ECHO: needs synchronised echo low then a rising edge; echo already high on entry is ignored until it falls. Echo of unselected channels ignored.
- MEASURE: µs prescaler cleared at rising edge; echo_us increments each US_CYC cycles of echo high (truncating partial µs), saturating at all-ones.
- Falling edge → DONE: mm = (echo_us × 11) >> 6, saturated to DIST_W bits; class = FAULT if mm ≤ FAULT_MM else CLEAR.
- Timeout: slot counter reaching PERIOD_CYC-2 while in WAIT_ECHO or MEASURE → DONE with class ERROR, meas_mm = 0.
- Confirmation per channel: if class == pending[ch], cnt[ch] increments (saturating at CONFIRM); else pending[ch] = class, cnt[ch] = 1. When cnt[ch] == CONFIRM and pending[ch] ≠ state[ch]: state[ch] ← pending, msg ← {pending, ch}, msg_valid pulse.
- Repeated identical confirmed states produce no further messages.

## Timing
- Reset: UV_trig, all LEDs, msg, msg_valid, meas_* all 0; all states UNK, cnt 0, pending UNK; FSM to TRIG, channel 0, slot cycle 0 on first cycle after reset deasserts.
- Reset mid-slot: trigger drops the cycle after reset is sampled; no message or meas_valid emitted for the aborted slot.
- Echo path: 2-FF synchroniser; edges act 2 cycles after pin change.
- DONE lasts 1 cycle: meas_valid and (if any) msg_valid/LED update occur in the same cycle, registered outputs visible next cycle.
- Slot length fixed at PERIOD_CYC regardless of echo end; GAP holds until slot counter wraps.
- Full scan period = N_CH × PERIOD_CYC.

## Structure
- Package uv_fault_pkg: state encodings, msg field positions, conversion constants (11, shift 6), channel index width 6.
- One sub-module: uv_echo_meter (synchroniser, edge detect, µs prescaler, echo_us counter, timeout); top holds scanner FSM, channel mux and per-channel confirm/state arrays.

## Test plan
- Defaults, ch0 echo 100 µs for 3 scans → meas_mm 17 each scan; on third, msg = 8'h80 pulse, led_R[0]=1.
- ch1 echo 300 µs ×3 → meas_mm 51, msg = 8'h41, led_G[1]=1; fourth identical scan → no msg_valid.
- ch2 no echo → meas_mm 0 each slot; after 3 scans msg = 8'hC2, led_B[2]=1.
- ch0 alternating 100/300 µs echoes → cnt never reaches 3, state stays, no msg_valid; CONFIRM=1 build → msg every scan alternating 8'h80/8'h40.
- Echo on ch1 pin held high across ch0's trigger → ignored; ch0 result unaffected; echo high at ch1 WAIT_ECHO entry only counted after fall-and-rise.
- Reset asserted mid-MEASURE on ch1 → trig low next cycle, all LEDs off, msg 8'h00, next trigger on ch0 at cycle 0 after release.
